// File: rtl/fsm_sequence_detector_param.sv
// ============================================================================
// fsm_sequence_detector_param: runtime-programmable serial pattern detector
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_sequence_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               data_in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clear_count,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill
);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0]   c_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   c_RST_LEN = LEN_W'((MAX_LEN < 4) ? MAX_LEN : 4);
  localparam logic [MAX_LEN-1:0] c_RST_PAT = MAX_LEN'(4'b1101);

  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   hist_q, hist_d;
  logic [LEN_W-1:0]     fill_q, fill_d;
  logic [MAX_LEN-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 ovl_q, ovl_d;
  logic                 det_q, det_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [MAX_LEN-1:0]   w_mask;
  logic [MAX_LEN-1:0]   w_hist_sh;
  logic [LEN_W-1:0]     w_fill_inc;
  logic [LEN_W-1:0]     w_len_clamp;
  logic                 w_hit;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(len_q));
    end
  end

  assign w_hist_sh   = {hist_q[MAX_LEN-2:0], data_in};
  assign w_fill_inc  = (fill_q >= c_MAX_LEN) ? c_MAX_LEN : fill_q + 1'b1;
  assign w_len_clamp = ((cfg_len == '0) || (cfg_len > c_MAX_LEN)) ? c_MAX_LEN : cfg_len;
  // Match is judged on the history as it will look after this bit shifts in.
  assign w_hit       = (w_fill_inc >= len_q) && (((w_hist_sh ^ pat_q) & w_mask) == '0);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    det_d   = 1'b0;
    cnt_d   = cnt_q;

    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = w_len_clamp;
      ovl_d   = cfg_overlap;
      fill_d  = '0;
      state_d = FILL;
    end else if (en) begin
      hist_d = w_hist_sh;
      fill_d = w_fill_inc;
      if (w_hit) begin
        det_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!ovl_q) begin
          fill_d = '0;
        end
      end
      state_d = (fill_d >= len_q) ? ARMED : FILL;
    end

    if (clear_count) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= c_RST_PAT;
      len_q   <= c_RST_LEN;
      ovl_q   <= 1'b1;
      det_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
    end
  end

  assign detected    = det_q;
  assign match_count = cnt_q;
  assign fill        = fill_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_sequence_detector_param.sv
// ============================================================================
// tb_fsm_sequence_detector_param: directed bench with a stream-level model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_sequence_detector_param;

  logic       clk = 1'b0;
  logic       rst, en, data_in, cfg_load, cfg_overlap, clear_count;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  logic        det1, det2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;
  logic [3:0]  fill1, fill2;

  int tests = 0;
  int fails = 0;

  // Model state: the raw consumed stream plus how many bits count since the last flush.
  bit   sq[$];
  int   fresh;
  logic [7:0] mpat;
  int   mlen;
  bit   movl;
  bit   exp_det;
  int   exp_cnt1, exp_cnt2, exp_fill;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  fsm_sequence_detector_param #(.MAX_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clear_count(clear_count), .detected(det1), .match_count(cnt1), .fill(fill1)
  );

  fsm_sequence_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clear_count(clear_count), .detected(det2), .match_count(cnt2), .fill(fill2)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("det",   int'(det1),  int'(exp_det));
      chk("cnt",   int'(cnt1),  exp_cnt1);
      chk("fill",  int'(fill1), exp_fill);
      chk("det2",  int'(det2),  int'(exp_det));
      chk("cnt2",  int'(cnt2),  exp_cnt2);
      chk("fill2", int'(fill2), exp_fill);
    end
  end

  task automatic model_edge(input bit r, input bit e, input bit d, input bit l, input bit c);
    bit hit;
    if (r) begin
      sq.delete();
      fresh = 0; mpat = 8'b0000_1101; mlen = 4; movl = 1'b1;
      exp_det = 1'b0; exp_cnt1 = 0; exp_cnt2 = 0;
      chk_en = 1'b1;
    end else begin
      exp_det = 1'b0;
      if (l) begin
        mpat  = cfg_pattern;
        mlen  = (cfg_len == 0 || cfg_len > 8) ? 8 : int'(cfg_len);
        movl  = cfg_overlap;
        fresh = 0;
      end else if (e) begin
        sq.push_back(d);
        fresh++;
        if (fresh >= mlen) begin
          hit = 1'b1;
          for (int k = 0; k < mlen; k++)
            if (sq[sq.size()-1-k] != mpat[k]) hit = 1'b0;
          if (hit) begin
            exp_det  = 1'b1;
            exp_cnt1 = (exp_cnt1 == 65535) ? exp_cnt1 : exp_cnt1 + 1;
            exp_cnt2 = (exp_cnt2 == 3) ? exp_cnt2 : exp_cnt2 + 1;
            if (!movl) fresh = 0;
          end
        end
      end
      if (c) begin
        exp_cnt1 = 0; exp_cnt2 = 0;
      end
    end
    exp_fill = (fresh > 8) ? 8 : fresh;
  endtask

  // One clock: drive inputs, take the edge, advance the model, return at negedge.
  task automatic cyc(input bit e, input bit d, input bit l = 0, input bit c = 0, input bit r = 0);
    en = e; data_in = d; cfg_load = l; clear_count = c; rst = r;
    @(posedge clk);
    model_edge(r, e, d, l, c);
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] n, input bit o, input bit c = 1);
    cfg_pattern = p; cfg_len = n; cfg_overlap = o;
    cyc(1'b1, 1'b1, 1'b1, c);
  endtask

  task automatic send(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, v[i]);
  endtask

  initial begin
    en = 0; data_in = 0; cfg_load = 0; clear_count = 0; rst = 1;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    cyc(0, 0, 0, 0, 1);
    chk("rst_det", int'(det1), 0);
    chk("rst_cnt", int'(cnt1), 0);
    chk("rst_fill", int'(fill1), 0);

    // Legacy 1101 defaults
    send(16'b1101, 4);
    chk("legacy_hit3", int'(det1), 1);
    send(16'b1101, 4);
    chk("legacy_hit7", int'(det1), 1);
    chk("legacy_cnt", int'(cnt1), 2);
    cyc(0, 0, 0, 0, 1);
    send(16'b10101010, 8);
    chk("alt_cnt", int'(cnt1), 0);

    // 1101 overlap vs non-overlap
    load(8'b1101, 4'd4, 1'b1);
    send(16'b1101101, 7);
    chk("ovl_cnt", int'(cnt1), 2);
    load(8'b1101, 4'd4, 1'b0);
    send(16'b1101101, 7);
    chk("novl_det6", int'(det1), 0);
    chk("novl_cnt", int'(cnt1), 1);

    // 111 overlap: four back-to-back pulses; non-overlap: two
    load(8'b111, 4'd3, 1'b1);
    send(16'b111111, 6);
    chk("run_ovl_cnt", int'(cnt1), 4);
    load(8'b111, 4'd3, 1'b0);
    send(16'b111111, 6);
    chk("run_novl_cnt", int'(cnt1), 2);

    // en gap keeps partial pattern; reset destroys it
    load(8'b1101, 4'd4, 1'b1);
    send(16'b110, 3);
    repeat (3) cyc(0, 1);
    cyc(1, 1);
    chk("gap_det", int'(det1), 1);
    send(16'b110, 3);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1);
    chk("rst_mid_det", int'(det1), 0);
    chk("rst_mid_fill", int'(fill1), 1);

    // len=1 saturation on the 2-bit counter, then clear coincident with a match
    load(8'b1, 4'd1, 1'b0);
    send(16'b11111, 5);
    chk("sat_cnt2", int'(cnt2), 3);
    chk("sat_cnt1", int'(cnt1), 5);
    cyc(1, 1, 0, 1);
    chk("clr_det", int'(det2), 1);
    chk("clr_cnt2", int'(cnt2), 0);

    // len 0 clamps to 8; mid-pattern load discards partial and its own bit
    load(8'b10110011, 4'd0, 1'b1);
    send(16'b1011001, 7);
    chk("len8_early", int'(det1), 0);
    cyc(1, 1);
    chk("len8_hit", int'(det1), 1);
    send(16'b1011, 4);
    load(8'b10110011, 4'd0, 1'b1, 0);
    send(16'b0011, 4);
    chk("midload_nohit", int'(det1), 0);
    send(16'b10110011, 8);
    chk("midload_hit", int'(det1), 1);
    load(8'b10110011, 4'd12, 1'b1);
    send(16'b10110011, 8);
    chk("len12_clamp", int'(det1), 1);

    cyc(0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
